// File: rtl/svm_window_classifier_pkg.sv
// Shared defaults and saturation helper for the linear-SVM window classifier.
package svm_window_classifier_pkg;

    localparam int SW_W_DEF   = 11;
    localparam int FEAT_W_DEF = 12;
    localparam int WGT_W_DEF  = 12;
    localparam int ACC_W_DEF  = 32;
    localparam int N_FEAT_DEF = 3780;
    localparam int N_SW_DEF   = 1200;

    localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    // Clamp a wide signed value to the signed range of a w-bit word (w <= 62).
    function automatic logic signed [63:0] sat_sum(input logic signed [63:0] v,
                                                    input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/svm_window_classifier_mac.sv
// Product register followed by a saturating load/accumulate stage with
// first/last/window-id sideband carried alongside.
module svm_mac
    import svm_window_classifier_pkg::*;
#(
    parameter int SW_W   = SW_W_DEF,
    parameter int FEAT_W = FEAT_W_DEF,
    parameter int WGT_W  = WGT_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  logic                     first_i,
    input  logic                     last_i,
    input  logic [SW_W-1:0]          id_i,
    input  logic signed [FEAT_W-1:0] feat_i,
    input  logic signed [WGT_W-1:0]  wgt_i,
    output logic signed [ACC_W-1:0]  acc_o,
    output logic                     last_o,
    output logic [SW_W-1:0]          id_o
);
    localparam int PROD_W = FEAT_W + WGT_W;

    logic                     p_valid_q;
    logic                     p_first_q;
    logic                     p_last_q;
    logic [SW_W-1:0]          p_id_q;
    logic signed [PROD_W-1:0] p_prod_q;
    logic signed [PROD_W-1:0] p_prod_d;

    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic                     a_last_q;
    logic                     a_last_d;
    logic [SW_W-1:0]          a_id_q;
    logic [SW_W-1:0]          a_id_d;

    assign p_prod_d = PROD_W'(feat_i) * PROD_W'(wgt_i);

    // A flush drops whatever product is in flight and any pending last flag.
    always_comb begin
        acc_d    = acc_q;
        a_last_d = 1'b0;
        a_id_d   = a_id_q;
        if (!flush_i && p_valid_q) begin
            a_last_d = p_last_q;
            a_id_d   = p_id_q;
            if (p_first_q) begin
                acc_d = ACC_W'(p_prod_q);
            end else begin
                acc_d = ACC_W'(sat_sum(64'(acc_q) + 64'(p_prod_q), ACC_W));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_q <= 1'b0;
            p_first_q <= 1'b0;
            p_last_q  <= 1'b0;
            p_id_q    <= '0;
            p_prod_q  <= '0;
            acc_q     <= '0;
            a_last_q  <= 1'b0;
            a_id_q    <= '0;
        end else begin
            p_valid_q <= valid_i;
            p_first_q <= first_i;
            p_last_q  <= last_i;
            p_id_q    <= id_i;
            p_prod_q  <= p_prod_d;
            acc_q     <= acc_d;
            a_last_q  <= a_last_d;
            a_id_q    <= a_id_d;
        end
    end

    assign acc_o  = acc_q;
    assign last_o = a_last_q;
    assign id_o   = a_id_q;

endmodule

// File: rtl/svm_window_classifier.sv
// Linear-SVM window scorer: feature/window counters, MAC pipeline, bias add,
// sign decision and held result registers.
module svm_window_classifier
    import svm_window_classifier_pkg::*;
#(
    parameter int SW_W   = SW_W_DEF,
    parameter int FEAT_W = FEAT_W_DEF,
    parameter int WGT_W  = WGT_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int N_FEAT = N_FEAT_DEF,
    parameter int N_SW   = N_SW_DEF,
    parameter logic signed [ACC_W-1:0] BIAS = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_sof,
    input  logic                     i_valid,
    input  logic signed [FEAT_W-1:0] i_feat,
    input  logic signed [WGT_W-1:0]  i_wgt,
    output logic                     o_valid,
    output logic                     is_person,
    output logic signed [ACC_W-1:0]  score,
    output logic [SW_W-1:0]          sw_id
);
    localparam int FC_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [FC_W-1:0] FCNT_LAST = FC_W'(N_FEAT - 1);
    localparam logic [SW_W-1:0] WCNT_LAST = SW_W'(N_SW - 1);

    logic [FC_W-1:0]         fcnt_q, fcnt_d, fcnt_cur;
    logic [SW_W-1:0]         wcnt_q, wcnt_d, wcnt_cur;
    logic                    feat_first, feat_last;

    logic signed [ACC_W-1:0] acc;
    logic                    acc_last;
    logic [SW_W-1:0]         acc_id;

    logic                    s_valid_q;
    logic signed [ACC_W-1:0] s_score_q, s_score_d;
    logic [SW_W-1:0]         s_id_q;

    logic                    o_valid_q, o_valid_d;
    logic                    is_person_q, is_person_d;
    logic signed [ACC_W-1:0] score_q, score_d;
    logic [SW_W-1:0]         sw_id_q, sw_id_d;

    // A start-of-frame restarts counting in the same cycle, so a coincident
    // pair lands as feature 0 of window 0.
    always_comb begin
        fcnt_cur   = i_sof ? '0 : fcnt_q;
        wcnt_cur   = i_sof ? '0 : wcnt_q;
        feat_first = (fcnt_cur == '0);
        feat_last  = (fcnt_cur == FCNT_LAST);
        fcnt_d     = fcnt_cur;
        wcnt_d     = wcnt_cur;
        if (i_valid) begin
            if (feat_last) begin
                fcnt_d = '0;
                wcnt_d = (wcnt_cur == WCNT_LAST) ? '0 : wcnt_cur + SW_W'(1);
            end else begin
                fcnt_d = fcnt_cur + FC_W'(1);
            end
        end
    end

    svm_mac #(
        .SW_W   (SW_W),
        .FEAT_W (FEAT_W),
        .WGT_W  (WGT_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .flush_i (i_sof),
        .valid_i (i_valid),
        .first_i (feat_first),
        .last_i  (feat_last),
        .id_i    (wcnt_cur),
        .feat_i  (i_feat),
        .wgt_i   (i_wgt),
        .acc_o   (acc),
        .last_o  (acc_last),
        .id_o    (acc_id)
    );

    assign s_score_d = ACC_W'(sat_sum(64'(acc) + 64'(BIAS), ACC_W));

    always_comb begin
        o_valid_d   = s_valid_q;
        is_person_d = is_person_q;
        score_d     = score_q;
        sw_id_d     = sw_id_q;
        if (s_valid_q) begin
            score_d     = s_score_q;
            is_person_d = !s_score_q[ACC_W-1] && (s_score_q != '0);
            sw_id_d     = s_id_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q      <= '0;
            wcnt_q      <= '0;
            s_valid_q   <= 1'b0;
            s_score_q   <= '0;
            s_id_q      <= '0;
            o_valid_q   <= 1'b0;
            is_person_q <= 1'b0;
            score_q     <= '0;
            sw_id_q     <= '0;
        end else begin
            fcnt_q      <= fcnt_d;
            wcnt_q      <= wcnt_d;
            s_valid_q   <= acc_last;
            s_score_q   <= s_score_d;
            s_id_q      <= acc_id;
            o_valid_q   <= o_valid_d;
            is_person_q <= is_person_d;
            score_q     <= score_d;
            sw_id_q     <= sw_id_d;
        end
    end

    assign o_valid   = o_valid_q;
    assign is_person = is_person_q;
    assign score     = score_q;
    assign sw_id     = sw_id_q;

endmodule

// File: tb/tb_svm_window_classifier.sv
// Bench for svm_window_classifier: directed window table, corner sequences,
// and randomized pairs checked cycle-by-cycle against a window-level model.
module tb_svm_window_classifier;
    localparam int SW_W   = 11;
    localparam int FEAT_W = 12;
    localparam int WGT_W  = 12;
    localparam int ACC_W  = 24;
    localparam int N_FEAT = 4;
    localparam int N_SW   = 3;
    localparam longint BIAS_V = -10;
    localparam longint AMAX = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (ACC_W - 1));

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     i_sof;
    logic                     i_valid;
    logic signed [FEAT_W-1:0] i_feat;
    logic signed [WGT_W-1:0]  i_wgt;
    logic                     o_valid;
    logic                     is_person;
    logic signed [ACC_W-1:0]  score;
    logic [SW_W-1:0]          sw_id;

    always #5 clk = ~clk;

    svm_window_classifier #(
        .SW_W(SW_W), .FEAT_W(FEAT_W), .WGT_W(WGT_W), .ACC_W(ACC_W),
        .N_FEAT(N_FEAT), .N_SW(N_SW), .BIAS(ACC_W'(BIAS_V))
    ) dut (
        .clk(clk), .rst(rst), .i_sof(i_sof), .i_valid(i_valid),
        .i_feat(i_feat), .i_wgt(i_wgt), .o_valid(o_valid),
        .is_person(is_person), .score(score), .sw_id(sw_id)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct { int cyc; longint score; int id; } ev_t;
    ev_t    pend[$];
    int     seen_id[$];
    int     seen_cyc[$];
    longint cur_acc;
    int     cur_n = 0;
    int     win = 0;
    longint exp_score = 0;
    int     exp_id = 0;
    bit     exp_person = 0;

    function automatic longint clamp(longint v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    task automatic check(string name, longint got, longint want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Window-level model: collects products per window, reports 3 edges
    // after the edge that samples the last feature.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            pend.delete();
            cur_n = 0; win = 0;
            exp_score = 0; exp_id = 0; exp_person = 0;
        end else begin
            if (i_sof) begin cur_n = 0; win = 0; end
            if (i_valid) begin
                longint p;
                p = longint'(i_feat) * longint'(i_wgt);
                cur_acc = (cur_n == 0) ? p : clamp(cur_acc + p);
                cur_n++;
                if (cur_n == N_FEAT) begin
                    pend.push_back('{cyc + 3, clamp(cur_acc + BIAS_V), win});
                    win = (win + 1) % N_SW;
                    cur_n = 0;
                end
            end
        end
    end

    initial forever begin
        bit ev;
        @(negedge clk);
        ev = 1'b0;
        if (pend.size() > 0 && pend[0].cyc == cyc) begin
            ev = 1'b1;
            exp_score  = pend[0].score;
            exp_id     = pend[0].id;
            exp_person = (pend[0].score > 0);
            void'(pend.pop_front());
        end
        n_vec++;
        if (o_valid !== ev || longint'(score) !== exp_score ||
            is_person !== exp_person || sw_id !== SW_W'(exp_id)) begin
            n_err++;
            $display("FAIL monitor cyc=%0d: got v=%0b s=%0d p=%0b id=%0d want v=%0b s=%0d p=%0b id=%0d",
                     cyc, o_valid, score, is_person, sw_id, ev, exp_score, exp_person, exp_id);
        end
        if (o_valid === 1'b1) begin
            seen_id.push_back(int'(sw_id));
            seen_cyc.push_back(cyc);
        end
    end

    task automatic pair(input int f, input int w, input bit sof = 1'b0);
        i_valid = 1'b1; i_feat = FEAT_W'(f); i_wgt = WGT_W'(w); i_sof = sof;
        @(posedge clk); #1;
        i_valid = 1'b0; i_sof = 1'b0; i_feat = '0; i_wgt = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic sof_pulse();
        i_sof = 1'b1;
        @(posedge clk); #1;
        i_sof = 1'b0;
    endtask

    task automatic wait_pulse(output int lat);
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin lat = n; break; end
        end
    endtask

    typedef struct {
        int     f[4];
        int     w[4];
        bit     gap;
        longint score;
        bit     person;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int lat;
        rst = 1'b1; i_sof = 1'b0; i_valid = 1'b0; i_feat = '0; i_wgt = '0;

        tbl[0] = '{'{1, 2, 3, 4},             '{1, 1, 1, 1},             0, 0, 0};
        tbl[1] = '{'{1, 2, 3, 4},             '{1, 1, 1, 1},             1, 0, 0};
        tbl[2] = '{'{5, 5, 5, 5},             '{1, 1, 1, 1},             0, 10, 1};
        tbl[3] = '{'{2047, 2047, 2047, 2047}, '{2047, 2047, 2047, 2047}, 0, 8388597, 1};
        tbl[4] = '{'{-2048, -2048, -2048, -2048}, '{2047, 2047, 2047, 2047}, 1, -8388608, 0};
        tbl[5] = '{'{11, 0, 0, 0},            '{1, 1, 1, 1},             0, 1, 1};
        tbl[6] = '{'{-3, 2, 1, 0},            '{1, 1, 1, 1},             0, -10, 0};
        tbl[7] = '{'{100, -50, 7, -2},        '{3, 4, -5, 6},            1, 43, 1};

        idle(2);
        check("reset o_valid", longint'(o_valid), 0);
        check("reset score", longint'(score), 0);
        check("reset is_person", longint'(is_person), 0);
        check("reset sw_id", longint'(sw_id), 0);
        rst = 1'b0;
        idle(1);

        sof_pulse();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                pair(tbl[i].f[j], tbl[i].w[j]);
                if (tbl[i].gap && j < 3) idle(1);
            end
            wait_pulse(lat);
            check($sformatf("tbl%0d latency", i), lat, 4);
            check($sformatf("tbl%0d score", i), longint'(score), tbl[i].score);
            check($sformatf("tbl%0d is_person", i), longint'(is_person), longint'(tbl[i].person));
            check($sformatf("tbl%0d sw_id", i), longint'(sw_id), i % N_SW);
        end
        idle(2);

        // back-to-back windows and sw_id wrap
        sof_pulse();
        seen_id.delete(); seen_cyc.delete();
        for (int i = 0; i < 16; i++) pair(5, 1);
        idle(6);
        check("b2b pulse count", seen_id.size(), 4);
        if (seen_id.size() == 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("b2b sw_id%0d", i), seen_id[i], i % N_SW);
            for (int i = 0; i < 3; i++)
                check($sformatf("b2b spacing%0d", i), seen_cyc[i+1] - seen_cyc[i], 4);
        end

        // start-of-frame discards a partial window
        sof_pulse();
        seen_id.delete();
        for (int i = 0; i < 4; i++) pair(i + 1, 1);
        pair(7, 1); pair(7, 1);
        sof_pulse();
        for (int i = 0; i < 4; i++) pair(5, 1);
        idle(6);
        check("sof pulse count", seen_id.size(), 2);
        if (seen_id.size() == 2) check("sof restart sw_id", seen_id[1], 0);
        check("sof restart score", longint'(score), 10);

        // start-of-frame coinciding with a valid pair counts it as feature 0
        seen_id.delete();
        pair(3, 3); pair(3, 3);
        pair(5, 1, 1'b1);
        for (int i = 0; i < 3; i++) pair(5, 1);
        idle(6);
        check("sof+valid pulse count", seen_id.size(), 1);
        if (seen_id.size() == 1) check("sof+valid sw_id", seen_id[0], 0);
        check("sof+valid score", longint'(score), 10);

        // reset in the middle of a window
        for (int i = 0; i < 4; i++) pair(2, 2);
        idle(5);
        check("pre-reset sw_id", longint'(sw_id), 1);
        seen_id.delete();
        pair(9, 9); pair(9, 9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid reset o_valid", longint'(o_valid), 0);
        check("mid reset score", longint'(score), 0);
        check("mid reset is_person", longint'(is_person), 0);
        check("mid reset sw_id", longint'(sw_id), 0);
        idle(5);
        check("no stale pulse", seen_id.size(), 0);
        for (int i = 0; i < 4; i++) pair(5, 1);
        idle(6);
        check("post-reset pulse count", seen_id.size(), 1);
        if (seen_id.size() == 1) check("post-reset sw_id", seen_id[0], 0);

        // randomized pairs with random idle gaps
        sof_pulse();
        for (int i = 0; i < 200; i++) begin
            int f, w;
            if ($urandom_range(0, 3) == 0) idle(1);
            if ($urandom_range(0, 7) == 0) begin
                f = ($urandom_range(0, 1) == 1) ? 2047 : -2048;
                w = ($urandom_range(0, 1) == 1) ? 2047 : -2048;
            end else begin
                f = int'($urandom_range(0, 4095)) - 2048;
                w = int'($urandom_range(0, 4095)) - 2048;
            end
            pair(f, w);
        end
        idle(8);
        check("all results reported", pend.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
